// File: rtl/amstrad_vram_pkg.sv
// rtl/amstrad_vram_pkg.sv - shared widths, state enum and address helper for the VRAM fetch unit
package amstrad_vram_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 16;
    localparam int MEM_AW  = 23;

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        STALE,
        PREFETCH
    } vram_state_t;

    function automatic logic [MEM_AW-1:0] byte_addr(input logic [6:0] bank,
                                                    input logic [VRAM_AW-1:0] word);
        return {bank, word, 1'b0};
    endfunction

endpackage

// File: rtl/amstrad_vram_fetch_if.sv
// rtl/amstrad_vram_fetch_if.sv - req/ack read bus between the fetch unit and the memory controller
interface amstrad_vram_fetch_if;
    import amstrad_vram_pkg::*;

    logic               mem_req;
    logic [MEM_AW-1:0]  mem_addr;
    logic               mem_ack;
    logic [VRAM_DW-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/amstrad_vram_req_ctl.sv
// rtl/amstrad_vram_req_ctl.sv - owns the req/ack handshake, in-flight address and request class
// Prefetch follow-up requests exist only with AMSTRAD_VRAM_PREFETCH_EN defined.
module amstrad_vram_req_ctl
    import amstrad_vram_pkg::*;
#(
    parameter logic [6:0] BASE_BANK = 7'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    amstrad_vram_fetch_if.master mem,
    input  logic                 stb,
    input  logic [VRAM_AW-1:0]   stb_addr,
    input  logic                 hit,
    input  logic                 pend_valid,
    input  logic [VRAM_AW-1:0]   pend_addr,
    output logic                 ack_demand,
    output logic                 ack_prefetch,
    output logic [VRAM_AW-1:0]   cur_word,
    output logic                 idle_next,
    output logic                 stb_late,
    output logic                 pend_take,
    output logic                 pend_load,
    output logic                 pend_drop
);

    vram_state_t        state;
    vram_state_t        post_state;
    logic               req;
    logic               post_req;
    logic               ack_fire;
    logic               pf_match;
    logic [MEM_AW-1:0]  addr;
    logic [VRAM_AW-1:0] word;
    logic [VRAM_AW-1:0] post_word;

    assign word         = addr[VRAM_AW:1];
    assign cur_word     = word;
    assign ack_fire     = mem.mem_ack & req;
    assign ack_demand   = ack_fire & (state == DEMAND);
    assign ack_prefetch = ack_fire & (state == PREFETCH);
    assign pend_take    = ack_fire & pend_valid;

    // Ack is resolved first; a follow-up request idles req for one cycle before rising.
    always_comb begin
        post_state = state;
        post_word  = word;
        post_req   = req;
        if (ack_fire) begin
            post_req = 1'b0;
            if (pend_valid) begin
                post_state = DEMAND;
                post_word  = pend_addr;
            end
`ifdef AMSTRAD_VRAM_PREFETCH_EN
            else if (state == DEMAND) begin
                post_state = PREFETCH;
                post_word  = word + VRAM_AW'(1);
            end
`endif
            else begin
                post_state = IDLE;
            end
        end else if (state != IDLE && !req) begin
            post_req = 1'b1;
        end
    end

    assign pf_match  = (post_state == PREFETCH) && (post_word == stb_addr);
    assign idle_next = (post_state == IDLE);
    assign stb_late  = stb & (post_state == DEMAND);
    assign pend_load = stb & (post_state != IDLE) & ~pf_match;
    assign pend_drop = stb & pf_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req   <= 1'b0;
            addr  <= byte_addr(BASE_BANK, '0);
        end else begin
            state <= post_state;
            req   <= post_req;
            addr  <= byte_addr(BASE_BANK, post_word);
            if (stb) begin
                case (post_state)
                    IDLE: begin
                        if (!hit) begin
                            state <= DEMAND;
                            req   <= 1'b1;
                            addr  <= byte_addr(BASE_BANK, stb_addr);
                        end
                    end
                    DEMAND:   state <= STALE;
                    PREFETCH: if (pf_match) state <= DEMAND;
                    default:  ;
                endcase
            end
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_addr = addr;

endmodule

// File: rtl/amstrad_vram_fetch.sv
// rtl/amstrad_vram_fetch.sv - Amstrad video-RAM fetch unit: pending strobe, output word, late counter
// Optional next-word prefetch buffer enabled by AMSTRAD_VRAM_PREFETCH_EN.
module amstrad_vram_fetch
    import amstrad_vram_pkg::*;
#(
    parameter logic [6:0] BASE_BANK = 7'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 addr_stb,
    input  logic [VRAM_AW-1:0]   vram_addr,
    output logic [VRAM_DW-1:0]   vram_dout,
    amstrad_vram_fetch_if.master mem,
    output logic                 late,
    output logic [7:0]           late_cnt
);

    logic               hit;
    logic               ack_demand;
    logic               ack_prefetch;
    logic               idle_next;
    logic               stb_late;
    logic               pend_take;
    logic               pend_load;
    logic               pend_drop;
    logic               pend_valid;
    logic [VRAM_AW-1:0] pend_addr;
    logic [VRAM_AW-1:0] cur_word;
    logic [VRAM_DW-1:0] hit_data;

    amstrad_vram_req_ctl #(.BASE_BANK(BASE_BANK)) u_req_ctl (
        .clk          (clk),
        .reset        (reset),
        .mem          (mem),
        .stb          (addr_stb),
        .stb_addr     (vram_addr),
        .hit          (hit),
        .pend_valid   (pend_valid),
        .pend_addr    (pend_addr),
        .ack_demand   (ack_demand),
        .ack_prefetch (ack_prefetch),
        .cur_word     (cur_word),
        .idle_next    (idle_next),
        .stb_late     (stb_late),
        .pend_take    (pend_take),
        .pend_load    (pend_load),
        .pend_drop    (pend_drop)
    );

`ifdef AMSTRAD_VRAM_PREFETCH_EN
    logic               pf_valid;
    logic               pf_valid_now;
    logic [VRAM_AW-1:0] pf_tag;
    logic [VRAM_AW-1:0] pf_tag_now;
    logic [VRAM_DW-1:0] pf_data;

    // A prefetch landing in the strobe cycle is already eligible for a hit.
    assign pf_valid_now = pf_valid | ack_prefetch;
    assign pf_tag_now   = ack_prefetch ? cur_word : pf_tag;
    assign hit_data     = ack_prefetch ? mem.mem_rdata : pf_data;
    assign hit          = addr_stb & idle_next & pf_valid_now & (pf_tag_now == vram_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_tag   <= '0;
            pf_data  <= '0;
        end else if (ack_prefetch) begin
            pf_valid <= 1'b1;
            pf_tag   <= cur_word;
            pf_data  <= mem.mem_rdata;
        end
    end
`else
    logic unused_pf;
    assign unused_pf = ^{ack_prefetch, cur_word, idle_next};
    assign hit       = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            if (pend_take || pend_drop) pend_valid <= 1'b0;
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_addr  <= vram_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_dout <= '0;
            late      <= 1'b0;
            late_cnt  <= 8'h00;
        end else begin
            if (hit)             vram_dout <= hit_data;
            else if (ack_demand) vram_dout <= mem.mem_rdata;
            late <= stb_late;
            if (stb_late && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_amstrad_vram_fetch.sv
// tb/tb_amstrad_vram_fetch.sv - lockstep reference-model bench for amstrad_vram_fetch
module tb_amstrad_vram_fetch;
    import amstrad_vram_pkg::*;

    localparam logic [6:0] BANK = 7'h05;
`ifdef AMSTRAD_VRAM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               addr_stb = 1'b0;
    logic [VRAM_AW-1:0] vram_addr = '0;
    logic [VRAM_DW-1:0] vram_dout;
    logic               late;
    logic [7:0]         late_cnt;

    amstrad_vram_fetch_if mem ();

    amstrad_vram_fetch #(.BASE_BANK(BANK)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_stb  (addr_stb),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .mem       (mem),
        .late      (late),
        .late_cnt  (late_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference: at most one outstanding read, described by where its data goes.
    bit          m_busy, m_req, m_for_dout, m_for_buf;
    logic [14:0] m_word, m_pend;
    bit          m_pend_v, m_buf_v, m_late;
    logic [14:0] m_buf_tag;
    logic [15:0] m_buf_data, m_dout;
    int          m_cnt;

    task automatic model_reset();
        m_busy = 0; m_req = 0; m_for_dout = 0; m_for_buf = 0;
        m_word = '0; m_pend = '0; m_pend_v = 0;
        m_buf_v = 0; m_buf_tag = '0; m_buf_data = '0;
        m_dout = '0; m_late = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit rst, input bit stb, input logic [14:0] a,
                              input bit ack, input logic [15:0] rd);
        bit was_demand;
        bit new_late;
        if (rst) begin
            model_reset();
            return;
        end
        new_late = 0;
        if (ack && m_req) begin
            was_demand = m_for_dout;
            if (m_for_buf) begin
                m_buf_v = 1; m_buf_tag = m_word; m_buf_data = rd;
            end else if (m_for_dout) begin
                m_dout = rd;
            end
            m_req = 0;
            if (m_pend_v) begin
                m_busy = 1; m_for_dout = 1; m_for_buf = 0; m_word = m_pend; m_pend_v = 0;
            end else if (PF && was_demand) begin
                m_busy = 1; m_for_dout = 0; m_for_buf = 1; m_word = m_word + 15'd1;
            end else begin
                m_busy = 0; m_for_dout = 0; m_for_buf = 0;
            end
        end else if (m_busy && !m_req) begin
            m_req = 1;
        end
        if (stb) begin
            if (!m_busy) begin
                if (PF && m_buf_v && m_buf_tag == a) m_dout = m_buf_data;
                else begin
                    m_busy = 1; m_for_dout = 1; m_for_buf = 0; m_word = a; m_req = 1;
                end
            end else if (m_for_dout) begin
                new_late = 1; m_for_dout = 0; m_pend_v = 1; m_pend = a;
            end else if (m_for_buf && m_word == a) begin
                m_for_buf = 0; m_for_dout = 1; m_pend_v = 0;
            end else begin
                m_pend_v = 1; m_pend = a;
            end
        end
        m_late = new_late;
        if (new_late && m_cnt < 255) m_cnt++;
    endtask

    int                lat = 3;
    int                age = 0;
    bit                rand_lat = 0;
    logic [15:0]       data_q[$];
    logic [MEM_AW-1:0] seen_addr = '0;

    task automatic tick(input bit rst, input bit stb, input logic [14:0] a, input bit fack);
        bit ack;
        logic [15:0] rd;
        @(negedge clk);
        check("mem_req", mem.mem_req, m_req);
        check("mem_addr", mem.mem_addr, {BANK, m_word, 1'b0});
        check("vram_dout", vram_dout, m_dout);
        check("late", late, m_late);
        check("late_cnt", late_cnt, m_cnt[7:0]);
        if (mem.mem_req) seen_addr = mem.mem_addr;
        ack = fack || (m_req && age >= lat);
        age = (m_req && !ack && !rst) ? age + 1 : 0;
        if (ack && data_q.size() > 0) rd = data_q.pop_front();
        else rd = 16'($urandom);
        if (ack && rand_lat) lat = $urandom_range(0, 12);
        reset = rst;
        addr_stb = stb;
        vram_addr = a;
        mem.mem_ack = ack;
        mem.mem_rdata = rd;
        model_step(rst, stb, a, ack, rd);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, 0);
    endtask

    initial begin
        bit          found;
        bit          s;
        bit          r;
        logic [14:0] ra;

        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        model_reset();
        tick(1, 0, '0, 0);
        tick(1, 0, '0, 0);
        #1;
        check("rst_dout", vram_dout, 16'h0000);
        check("rst_req", mem.mem_req, 1'b0);
        check("rst_addr", mem.mem_addr, {BANK, 16'h0000});
        check("rst_late_cnt", late_cnt, 8'h00);

        // First demand read
        data_q.push_back(16'hBEEF);
        tick(0, 1, 15'h1234, 0);
        #1;
        check("t1_req", mem.mem_req, 1'b1);
        check("t1_addr", mem.mem_addr, {BANK, 16'h2468});
        idle(10);
        check("t1_dout", vram_dout, 16'hBEEF);
        check("t1_late", late, 1'b0);
        idle(15);

`ifdef AMSTRAD_VRAM_PREFETCH_EN
        data_q.push_back(16'h1111);
        data_q.push_back(16'h2222);
        tick(0, 1, 15'h0010, 0);
        idle(14);
        check("pf_addr", seen_addr, {BANK, 15'h0011, 1'b0});
        tick(0, 1, 15'h0011, 0);
        #1;
        check("hit_dout", vram_dout, 16'h2222);
        check("hit_noreq", mem.mem_req, 1'b0);
        idle(5);
        tick(0, 1, 15'h7FFF, 0);
        idle(14);
        check("wrap_addr", seen_addr, {BANK, 16'h0000});
        idle(5);
`endif

        // Stall: second strobe arrives while the first demand is still outstanding
        lat = 20;
        data_q.push_back(16'hDEAD);
        data_q.push_back(16'hCAFE);
        tick(0, 1, 15'h0100, 0);
        idle(15);
        tick(0, 1, 15'h0200, 0);
        #1;
        check("stall_late", late, 1'b1);
        check("stall_addr_held", mem.mem_addr, {BANK, 15'h0100, 1'b0});
        idle(40);
        check("stall_dout", vram_dout, 16'hCAFE);
        check("stall_cnt", late_cnt, 8'h01);
        lat = 3;
        idle(30);

        // Strobe coinciding with the ack of the previous demand
        data_q.push_back(16'h3333);
        tick(0, 1, 15'h0300, 0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_req && age >= lat) begin
                tick(0, 1, 15'h0301, 0);
                found = 1;
            end else begin
                tick(0, 0, '0, 0);
            end
        end
        check("b2b_found", found, 1'b1);
        #1;
        check("b2b_dout", vram_dout, 16'h3333);
`ifndef AMSTRAD_VRAM_PREFETCH_EN
        check("b2b_req", mem.mem_req, 1'b1);
        check("b2b_addr", mem.mem_addr, {BANK, 15'h0301, 1'b0});
`endif
        idle(20);

        // Reset while a request is outstanding, then a stray ack
        tick(0, 1, 15'h0400, 0);
        tick(1, 0, '0, 0);
        #1;
        check("rst_mid_req", mem.mem_req, 1'b0);
        tick(0, 0, '0, 1);
        #1;
        check("post_rst_dout", vram_dout, 16'h0000);
        check("post_rst_req", mem.mem_req, 1'b0);
        check("post_rst_addr", mem.mem_addr, {BANK, 16'h0000});
        check("post_rst_late", late, 1'b0);
        check("post_rst_cnt", late_cnt, 8'h00);

        // Randomised traffic: mostly sequential strobes every 16 cycles
        rand_lat = 1;
        ra = 15'($urandom);
        for (int c = 0; c < 3000; c++) begin
            s = (c % 16 == 0) || ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 999) == 0);
            if (s) begin
                if ($urandom_range(0, 9) < 7) ra = ra + 15'd1;
                else if ($urandom_range(0, 3) == 0) ra = 15'h7FFF;
                else ra = 15'($urandom);
            end
            tick(r, s, ra, 0);
        end

        // Counter saturation under continuous strobes
        rand_lat = 0;
        lat = 1;
        for (int c = 0; c < 1000; c++) tick(0, 1, 15'($urandom), 0);
        #1;
        check("sat_cnt", late_cnt, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
